// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver that delivers each byte through a valid/ack handshake on sysclk.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       serialIn,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 32'sd2) - 32'sd1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 32'sd1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [7:0]       shift_r, shift_nxt_s;
  logic             sync1_r, sync2_r, prev_r;
  logic             fall_s;
  logic             stop_ok_s, ferr_s, perr_s;

`ifdef SERIAL_RX_PARITY_EN
  logic par_r, par_nxt_s;

  // Returns 1 when data plus parity bit do not have even parity.
  function automatic logic parity_bad(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  // Two-flop synchroniser plus edge-detect history; presets high so reset never looks like a start bit.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= serialIn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign fall_s = prev_r & ~sync2_r;

  // Frame state, bit-period counter, bit index and shift register.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
`ifdef SERIAL_RX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
`ifdef SERIAL_RX_PARITY_EN
      par_r   <= par_nxt_s;
`endif
    end
  end

  // Next-state logic; every sample point is an equality compare, after which the counter restarts.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_ONE;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    stop_ok_s   = 1'b0;
    ferr_s      = 1'b0;
    perr_s      = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_nxt_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        idx_nxt_s = 3'd0;
        if (fall_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (sync2_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (cnt_r == FULL_LAST) begin
          cnt_nxt_s          = CNT_ZERO;
          shift_nxt_s[idx_r] = sync2_r;
          if (idx_r == 3'd7) begin
            idx_nxt_s = 3'd0;
`ifdef SERIAL_RX_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == FULL_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          par_nxt_s   = sync2_r;
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (cnt_r == FULL_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
`ifdef SERIAL_RX_PARITY_EN
          if (parity_bad(shift_r, par_r)) begin
            perr_s = 1'b1;
          end else if (!sync2_r) begin
            ferr_s = 1'b1;
          end else begin
            stop_ok_s = 1'b1;
          end
`else
          if (!sync2_r) begin
            ferr_s = 1'b1;
          end else begin
            stop_ok_s = 1'b1;
          end
`endif
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Registered outputs: byte handoff, error pulses and busy.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err  <= ferr_s;
      parity_err <= perr_s;
      overrun    <= stop_ok_s & rx_valid & ~rx_ack;
      busy       <= (state_nxt_s != IDLE);
      // A completing byte wins over an ack in the same cycle; otherwise the held byte is kept.
      if (stop_ok_s && (!rx_valid || rx_ack)) begin
        rx_data  <= shift_r;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule
